// File: rtl/syndrome_weight_acc.sv
// Sequential syndrome-weight unit: latches a syndrome on start and popcounts it
// CHUNK bits per clock, publishing weight, zero-syndrome and threshold flags.
module syndrome_weight_acc #(
    parameter int S_LENGTH = 256,
    parameter int CHUNK    = 32,
    parameter int SUM_BITS = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [S_LENGTH-1:0] s_data,
    input  logic [SUM_BITS-1:0] thr,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [SUM_BITS-1:0] sum,
    output logic                zero,
    output logic                ge_thr
);

    localparam int NCH   = S_LENGTH / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [S_LENGTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SUM_BITS-1:0] acc_q, acc_d;
    logic [SUM_BITS-1:0] thr_q, thr_d;
    logic [SUM_BITS-1:0] sum_q, sum_d;
    logic                zero_q, zero_d;
    logic                ge_q, ge_d;
    logic                done_q, done_d;
    logic [SUM_BITS-1:0] acc_next;

    function automatic logic [SUM_BITS-1:0] popcount_chunk(input logic [CHUNK-1:0] v);
        logic [SUM_BITS-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + SUM_BITS'(v[i]);
        end
        return c;
    endfunction

    assign acc_next = acc_q + popcount_chunk(shift_q[CHUNK-1:0]);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        thr_d   = thr_q;
        sum_d   = sum_q;
        zero_d  = zero_q;
        ge_d    = ge_q;
        done_d  = 1'b0;
        case (state_q)
            S_ACCUM: begin
                acc_d   = acc_next;
                shift_d = shift_q >> CHUNK;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CHUNK) begin
                    state_d = S_DONE;
                    sum_d   = acc_next;
                    zero_d  = (acc_next == '0);
                    ge_d    = (acc_next >= thr_q);
                    done_d  = 1'b1;
                end
            end
            // IDLE, DONE (and any unreachable code) accept a new start
            default: begin
                if (start) begin
                    state_d = S_ACCUM;
                    shift_d = s_data;
                    thr_d   = thr;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            thr_q   <= '0;
            sum_q   <= '0;
            zero_q  <= 1'b0;
            ge_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            thr_q   <= thr_d;
            sum_q   <= sum_d;
            zero_q  <= zero_d;
            ge_q    <= ge_d;
            done_q  <= done_d;
        end
    end

    assign ready  = (state_q != S_ACCUM);
    assign busy   = (state_q == S_ACCUM);
    assign done   = done_q;
    assign sum    = sum_q;
    assign zero   = zero_q;
    assign ge_thr = ge_q;

endmodule

// File: tb/tb_syndrome_weight_acc.sv
// Bench for syndrome_weight_acc: default 256/32 instance plus a 64/64 single-chunk instance.
module tb_syndrome_weight_acc;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [255:0] s_data = '0;
    logic [8:0]   thr = '0;
    logic         ready, busy, done, zero, ge_thr;
    logic [8:0]   sum;

    logic         start2 = 1'b0;
    logic [63:0]  s_data2 = '0;
    logic [6:0]   thr2 = '0;
    logic         ready2, busy2, done2, zero2, ge_thr2;
    logic [6:0]   sum2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    syndrome_weight_acc #(.S_LENGTH(256), .CHUNK(32), .SUM_BITS(9)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .thr(thr),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .zero(zero), .ge_thr(ge_thr)
    );

    syndrome_weight_acc #(.S_LENGTH(64), .CHUNK(64), .SUM_BITS(7)) dut_small (
        .clk(clk), .rst(rst), .start(start2), .s_data(s_data2), .thr(thr2),
        .ready(ready2), .busy(busy2), .done(done2), .sum(sum2), .zero(zero2), .ge_thr(ge_thr2)
    );

    // Reference: weight is the number of ones; flags follow from plain integer compares.
    function automatic int model_weight(input logic [255:0] v);
        return $countones(v);
    endfunction

    task automatic start_op(input logic [255:0] d, input logic [8:0] t);
        start  = 1'b1;
        s_data = d;
        thr    = t;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sum !== 9'd0) begin failures++; $display("FAIL reset_sum: got %0d expected 0", sum); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero: got %b expected 0", zero); end
        checks++; if (ge_thr !== 1'b0) begin failures++; $display("FAIL reset_ge: got %b expected 0", ge_thr); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ready2 !== 1'b1 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_small: got ready=%b busy=%b expected ready=1 busy=0", ready2, busy2); end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int c;
        start_op(256'd134, 9'd4);
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL basic_busy: got busy=%b ready=%b expected busy=1 ready=0", busy, ready); end
        wait_done(c);
        checks++; if (c != 8) begin failures++; $display("FAIL basic_latency: got %0d expected 8", c); end
        checks++; if (sum !== 9'd3) begin failures++; $display("FAIL basic_sum: got %0d expected 3", sum); end
        checks++; if (zero !== 1'b0 || ge_thr !== 1'b0) begin failures++; $display("FAIL basic_flags: got zero=%b ge=%b expected zero=0 ge=0", zero, ge_thr); end
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done_state: got ready=%b busy=%b expected ready=1 busy=0", ready, busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        checks++; if (sum !== 9'd3) begin failures++; $display("FAIL basic_hold: got %0d expected 3", sum); end
    endtask

    task automatic test_extremes;
        int c;
        start_op('0, 9'd0);
        wait_done(c);
        checks++; if (c != 8 || sum !== 9'd0) begin failures++; $display("FAIL zero_vec: got sum=%0d lat=%0d expected sum=0 lat=8", sum, c); end
        checks++; if (zero !== 1'b1 || ge_thr !== 1'b1) begin failures++; $display("FAIL zero_flags: got zero=%b ge=%b expected zero=1 ge=1", zero, ge_thr); end
        start_op('1, 9'd256);
        wait_done(c);
        checks++; if (c != 8 || sum !== 9'd256) begin failures++; $display("FAIL ones_vec: got sum=%0d lat=%0d expected sum=256 lat=8", sum, c); end
        checks++; if (zero !== 1'b0 || ge_thr !== 1'b1) begin failures++; $display("FAIL ones_flags: got zero=%b ge=%b expected zero=0 ge=1", zero, ge_thr); end
    endtask

    task automatic test_chunk_boundaries;
        logic [255:0] d;
        int c;
        d = '0;
        d[0] = 1'b1; d[31] = 1'b1; d[224] = 1'b1; d[255] = 1'b1;
        start_op(d, 9'd4);
        start = 1'b1;
        c = 0;
        while (!done && c < 40) begin
            for (int k = 0; k < 8; k++) s_data[k*32 +: 32] = $urandom;
            thr = 9'($urandom);
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        checks++; if (c != 8) begin failures++; $display("FAIL boundary_latency: got %0d expected 8", c); end
        checks++; if (sum !== 9'd4) begin failures++; $display("FAIL boundary_sum: got %0d expected 4", sum); end
        checks++; if (ge_thr !== 1'b1 || zero !== 1'b0) begin failures++; $display("FAIL boundary_flags: got ge=%b zero=%b expected ge=1 zero=0", ge_thr, zero); end
    endtask

    task automatic test_random;
        logic [255:0] d;
        logic [8:0] t;
        int w, tt, c;
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (i % 3 == 1) d[k*32 +: 32] = $urandom & $urandom & $urandom;
                else if (i % 3 == 2) d[k*32 +: 32] = $urandom | $urandom;
                else d[k*32 +: 32] = $urandom;
            end
            w = model_weight(d);
            if (i % 2 == 0) tt = $urandom_range(0, 256);
            else begin
                tt = w + $urandom_range(0, 2) - 1;
                if (tt < 0) tt = 0;
            end
            t = 9'(tt);
            start_op(d, t);
            wait_done(c);
            checks++; if (c != 8) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 8", i, c); end
            checks++; if (sum !== 9'(w)) begin failures++; $display("FAIL rand_sum[%0d]: got %0d expected %0d", i, sum, w); end
            checks++; if (zero !== (w == 0) || ge_thr !== (w >= tt)) begin failures++; $display("FAIL rand_flags[%0d]: got zero=%b ge=%b expected zero=%b ge=%b", i, zero, ge_thr, w == 0, w >= tt); end
        end
    endtask

    task automatic test_back_to_back;
        logic [255:0] d;
        int w, c;
        bit held_ok;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        w = model_weight(d);
        start_op(d, 9'd100);
        wait_done(c);
        checks++; if (sum !== 9'(w)) begin failures++; $display("FAIL b2b_first: got %0d expected %0d", sum, w); end
        start_op(256'hFF, 9'd8);
        held_ok = 1'b1;
        c = 0;
        while (!done && c < 40) begin
            if (sum !== 9'(w)) held_ok = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        checks++; if (!held_ok) begin failures++; $display("FAIL b2b_hold: got changed result expected %0d held", w); end
        checks++; if (c != 8) begin failures++; $display("FAIL b2b_latency: got %0d expected 8", c); end
        checks++; if (sum !== 9'd8 || ge_thr !== 1'b1) begin failures++; $display("FAIL b2b_second: got sum=%0d ge=%b expected sum=8 ge=1", sum, ge_thr); end
    endtask

    task automatic test_reset_mid;
        logic [255:0] d;
        int w, c;
        bit quiet;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom | 32'h1;
        start_op(d, 9'd5);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL midrst_ctrl: got busy=%b ready=%b done=%b expected 0 1 0", busy, ready, done); end
        checks++; if (sum !== 9'd0 || zero !== 1'b0 || ge_thr !== 1'b0) begin failures++; $display("FAIL midrst_outs: got sum=%0d zero=%b ge=%b expected 0 0 0", sum, zero, ge_thr); end
        @(negedge clk) rst = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || ready !== 1'b1) quiet = 1'b0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL midrst_nodone: got activity expected idle"); end
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        w = model_weight(d);
        start_op(d, 9'(w));
        wait_done(c);
        checks++; if (c != 8 || sum !== 9'(w) || ge_thr !== 1'b1) begin failures++; $display("FAIL midrst_restart: got sum=%0d lat=%0d ge=%b expected sum=%0d lat=8 ge=1", sum, c, ge_thr, w); end
    endtask

    task automatic test_single_chunk;
        logic [63:0] d;
        int w, tt, c;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) d = '1;
            else if (i == 1) d = '0;
            else d = {$urandom, $urandom};
            w = $countones(d);
            tt = (i == 0) ? 64 : (i == 1) ? 0 : $urandom_range(0, 64);
            start2 = 1'b1; s_data2 = d; thr2 = 7'(tt);
            @(posedge clk); #1;
            start2 = 1'b0;
            checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL small_busy[%0d]: got %b expected 1", i, busy2); end
            c = 0;
            while (!done2 && c < 10) begin
                @(posedge clk); #1;
                c++;
            end
            checks++; if (c != 1) begin failures++; $display("FAIL small_latency[%0d]: got %0d expected 1", i, c); end
            checks++; if (sum2 !== 7'(w) || zero2 !== (w == 0) || ge_thr2 !== (w >= tt)) begin failures++; $display("FAIL small_result[%0d]: got sum=%0d zero=%b ge=%b expected sum=%0d zero=%b ge=%b", i, sum2, zero2, ge_thr2, w, w == 0, w >= tt); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_chunk_boundaries();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_single_chunk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
